// File: rtl/pixel_uart_pkg.sv
// Shared constants and frame-FSM state encoding for the pixel UART transmitter.
// Bit indices count start (0), data (1..8) and stop (9) within one 8N1 byte.
package pixel_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned PIX_W      = 12;

  localparam int unsigned BIT_W = 4;
  localparam logic [BIT_W-1:0] BIT_START     = 4'd0;
  localparam logic [BIT_W-1:0] BIT_LAST_DATA = 4'd8;
  localparam logic [BIT_W-1:0] BIT_STOP      = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSendHi,
    StSendLo,
    StFinish
  } frame_state_e;

  function automatic logic [7:0] hi_byte(input logic [PIX_W-1:0] pix);
    return pix[11:4];
  endfunction

  function automatic logic [7:0] lo_byte(input logic [PIX_W-1:0] pix);
    return {pix[3:0], 4'b0000};
  endfunction

endpackage

// File: rtl/pixel_uart_tx_byte.sv
// 8N1 byte serializer with its own baud tick generator.
// tx_done is high during the last clock of the stop bit so the caller can queue the next byte.
module uart_tx_byte
  import pixel_uart_pkg::*;
#(
  parameter int unsigned TIMER_FINAL_VALUE = 650
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned TIMER_W = $clog2(TIMER_FINAL_VALUE + 2);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_FINAL_VALUE);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(OVERSAMPLE - 1);

  logic               active_q, active_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               tick;
  logic               bit_end;

  assign tick    = active_q && (timer_q == TIMER_LAST);
  assign bit_end = tick && (tick_cnt_q == TICK_LAST);
  assign tx_done = bit_end && (bit_cnt_q == BIT_STOP);
  assign tx      = tx_q;

  always_comb begin
    active_d   = active_q;
    timer_d    = timer_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    if (!active_q) begin
      if (tx_start) begin
        // Start bit goes out on the same edge the byte is accepted.
        active_d   = 1'b1;
        timer_d    = '0;
        tick_cnt_d = '0;
        bit_cnt_d  = BIT_START;
        shift_d    = tx_data;
        tx_d       = 1'b0;
      end
    end else begin
      timer_d = tick ? '0 : timer_q + TIMER_W'(1);
      if (tick) begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
      if (bit_end) begin
        if (bit_cnt_q == BIT_STOP) begin
          active_d   = 1'b0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST_DATA) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      timer_q    <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      active_q   <= active_d;
      timer_q    <= timer_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/pixel_uart_tx.sv
// Streams one frame of 12-bit pixels from an external frame memory over UART,
// two bytes per pixel in address order.
module pixel_uart_tx
  import pixel_uart_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH       = 4,
  parameter int unsigned IMAGE_HEIGHT      = 4,
  parameter int unsigned TIMER_FINAL_VALUE = 650,
  localparam int unsigned ADDR_W           = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              tx
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  frame_state_e      state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_byte;
  logic              tx_done;

  // The serializer copies its byte on tx_start, so a state-based mux suffices here.
  assign tx_byte = (state_q == StSendLo) ? lo_byte(pix_q) : hi_byte(pix_q);

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    pix_d      = pix_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        pix_d      = rd_data;
        tx_start_d = 1'b1;
        state_d    = StSendHi;
      end
      StSendHi: begin
        if (tx_done) begin
          tx_start_d = 1'b1;
          state_d    = StSendLo;
        end
      end
      StSendLo: begin
        if (tx_done) begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d = StFinish;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_en_d   = 1'b1;
            state_d   = StFetch;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pix_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pix_q      <= pix_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
    end
  end

  uart_tx_byte #(
    .TIMER_FINAL_VALUE(TIMER_FINAL_VALUE)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start_q),
    .tx_data (tx_byte),
    .tx_done (tx_done),
    .tx      (tx)
  );

endmodule

// File: doc/pixel_uart_tx.md
PIXEL_UART_TX -- requirements
Module: pixel_uart_tx

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 4, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 4, lines per frame.
REQ-003 SHALL have parameter TIMER_FINAL_VALUE, default 650, baud tick divider (tick every TIMER_FINAL_VALUE+1 clocks; 16 ticks per bit; 9600 bps at 100 MHz).
REQ-004 SHALL define ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
REQ-005 SHALL have port clk  in  1  system clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle request to transmit one frame.
REQ-008 SHALL have port busy  out  1  high from accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse after final stop bit of frame.
REQ-010 SHALL have port rd_en  out  1  frame-memory read strobe.
REQ-011 SHALL have port rd_addr  out  ADDR_W  frame-memory read address.
REQ-012 SHALL have port rd_data  in  12  pixel {R,G,B}, valid one clock after rd_en.
REQ-013 SHALL have port tx  out  1  UART serial line, 8N1, idle high.

Function
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-015 SHALL send pixels in address order 0 .. IMAGE_WIDTH*IMAGE_HEIGHT-1, each address read exactly once.
REQ-016 SHALL send each pixel as two bytes: first rd_data[11:4], then {rd_data[3:0],4'b0000}.
REQ-017 SHALL latch rd_data into a 12-bit holding register on the cycle after rd_en; rd_en SHALL be a single-cycle pulse per pixel.
REQ-018 SHALL use states IDLE -> FETCH (rd_en=1) -> LATCH -> SEND_HI -> SEND_LO -> (last address ? FINISH : FETCH); FINISH -> IDLE with done=1 for one cycle.
REQ-019 SHALL serialize each byte: start bit 0, data bits LSB first, one stop bit 1, each bit 16 ticks long.
REQ-020 SHALL begin the next byte's start bit no later than 3 clocks after the previous stop bit ends; tx SHALL stay high in between.
REQ-021 SHALL hold tx high whenever no byte is in flight.
REQ-022 SHALL free-run the tick counter only while a byte is in flight, restarting from 0 at each start bit.
REQ-023 SHALL assert done only after the final stop bit completes; busy SHALL fall in the same cycle done rises.
REQ-024 SHALL accept a start asserted in the cycle after done as a new frame, restarting at address 0.
REQ-025 SHALL transmit exactly 2*IMAGE_WIDTH*IMAGE_HEIGHT bytes per frame; rd_addr SHALL not wrap within a frame.

Reset
REQ-026 SHALL on rst force: state IDLE, tx=1, busy=0, done=0, rd_en=0, rd_addr=0, holding register=0, tick and bit counters=0.
REQ-027 SHALL abort any frame or byte in progress on rst without completing the byte; no done pulse SHALL follow.

Structure
REQ-028 SHALL place state encoding, byte-phase constants and the 16-tick oversample constant in shared package pixel_uart_pkg.
REQ-029 SHALL contain one sub-module uart_tx_byte (baud tick, 8N1 shifter, tx_start/tx_done handshake); framing FSM stays in pixel_uart_tx.

Verification (TIMER_FINAL_VALUE=0, i.e. 16 clocks per bit)
REQ-030 SHALL check: assert rst mid-run -> tx=1, busy=0, done=0, rd_en=0 immediately, asynchronously.
REQ-031 SHALL check: mem[0]=12'hABC, start -> tx sends 0xAB (bits 1,1,0,1,0,1,0,1 after 16-clock low start) then 0xC0.
REQ-032 SHALL check: 4x4 frame, mem[a]=a*12'h111 -> 32 bytes 00,00,11,10,22,20,...,FF,F0; rd_addr 0..15 once each; one done pulse.
REQ-033 SHALL check: start pulsed during byte 5 -> ignored, still 32 bytes, one done.
REQ-034 SHALL check: rst during data bit 3 of byte 2 -> tx high, no done; fresh start resends from address 0.
REQ-035 SHALL check: start in cycle after done -> second frame identical to first, no gap bytes.
